// File: rtl/mem_slave_regfile_if.sv
// Request/acknowledge bus between a configuration master and the register-file slave.
// The master holds its request fields stable until it sees mem_ack.
interface mem_slave_regfile_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_sel_en;
    logic                  mem_wr_rd_s;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_ack;
    logic                  mem_err;

    modport master (
        output mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_ack, mem_err
    );

    modport slave (
        input  mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
        output mem_rd_data, mem_ack, mem_err
    );
endinterface

// File: rtl/mem_slave_regfile.sv
// Parametrised register-file slave on the mem_* bus with programmable ack latency,
// read-only ID register at index 0, error response and a flat configuration output.
module mem_slave_regfile #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 16,
    parameter int                    ACK_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(8'hA5)
) (
    input  logic                        clock,
    input  logic                        reset,
    mem_slave_regfile_if.slave          bus,
    output logic [DEPTH*DATA_WIDTH-1:0] cfg_regs
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK, ST_HOLD} state_t;

    // DEPTH may equal 2**ADDR_WIDTH, so the range compare needs one extra bit.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0]          CNT_LOAD    = 4'(ACK_LATENCY - 1);

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;

    logic                    wr_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;

    logic                    cur_wr;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_wdata;

    logic                    enter_ack;
    logic                    addr_in_range;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   rd_sel;

    logic                    ack_reg, ack_next;
    logic                    err_reg, err_next;
    logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;

    logic [DATA_WIDTH-1:0]   regs_reg [1:DEPTH-1];

    // With ACK_LATENCY=1 the transaction completes on the capture edge, so the
    // live bus fields are used in IDLE and the captured copies afterwards.
    always_comb begin
        if (state_reg == ST_IDLE) begin
            cur_wr    = bus.mem_wr_rd_s;
            cur_addr  = bus.mem_addr;
            cur_wdata = bus.mem_wr_data;
        end else begin
            cur_wr    = wr_reg;
            cur_addr  = addr_reg;
            cur_wdata = wdata_reg;
        end
    end

    assign addr_in_range = ({1'b0, cur_addr} < DEPTH_LIMIT);
    assign illegal       = !addr_in_range || (cur_wr && (cur_addr == '0));

    always_comb begin
        rd_sel = ID_VALUE;
        for (int i = 1; i < DEPTH; i++) begin
            if (cur_addr == ADDR_WIDTH'(i)) begin
                rd_sel = regs_reg[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.mem_sel_en) begin
                    cnt_next   = CNT_LOAD;
                    state_next = (ACK_LATENCY == 1) ? ST_ACK : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.mem_sel_en) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from the next state and registered, so the ack
    // cycle coincides with the ACK state and no input reaches an output directly.
    always_comb begin
        enter_ack    = (state_next == ST_ACK);
        ack_next     = enter_ack;
        err_next     = enter_ack && illegal;
        rd_data_next = '0;
        if (enter_ack && !cur_wr && !illegal) begin
            rd_data_next = rd_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            ack_reg     <= ack_next;
            err_reg     <= err_next;
            rd_data_reg <= rd_data_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (state_reg == ST_IDLE && bus.mem_sel_en) begin
            wr_reg    <= bus.mem_wr_rd_s;
            addr_reg  <= bus.mem_addr;
            wdata_reg <= bus.mem_wr_data;
        end
    end

    assign cfg_regs[0 +: DATA_WIDTH] = ID_VALUE;

    // Register 0 is the constant ID; only indices 1..DEPTH-1 are storage.
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clock) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (enter_ack && cur_wr && (cur_addr == ADDR_WIDTH'(gi))) begin
                    regs_reg[gi] <= cur_wdata;
                end
            end
            assign cfg_regs[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
        end
    endgenerate

    assign bus.mem_ack     = ack_reg;
    assign bus.mem_err     = err_reg;
    assign bus.mem_rd_data = rd_data_reg;
endmodule

// File: tb/tb_mem_slave_regfile.sv
// Directed bench for mem_slave_regfile: four instances cover latency 1, 3, 4
// and a 16-bit data / 4-bit address / depth-4 configuration.
module tb_mem_slave_regfile;
    logic clk;
    logic [3:0] rst;
    logic [3:0] sel_en;
    logic [3:0] wr_rd;
    logic [7:0] addr [4];
    logic [15:0] wdata [4];

    logic [3:0] ack;
    logic [3:0] err;
    logic [3:0][15:0] rdata;
    logic [3:0][127:0] cfg;

    logic [127:0] cfg0, cfg1, cfg2;
    logic [63:0] cfgw;
    logic [127:0] cfg_snap;

    int vectors = 0;
    int miscompares = 0;

    mem_slave_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus0 ();
    mem_slave_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus1 ();
    mem_slave_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus2 ();
    mem_slave_regfile_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) busw ();

    mem_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .ACK_LATENCY(1))
        u_l1 (.clock(clk), .reset(rst[0]), .bus(bus0.slave), .cfg_regs(cfg0));
    mem_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .ACK_LATENCY(3))
        u_l3 (.clock(clk), .reset(rst[1]), .bus(bus1.slave), .cfg_regs(cfg1));
    mem_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(16), .ACK_LATENCY(4))
        u_l4 (.clock(clk), .reset(rst[2]), .bus(bus2.slave), .cfg_regs(cfg2));
    mem_slave_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(4), .ACK_LATENCY(2))
        u_w (.clock(clk), .reset(rst[3]), .bus(busw.slave), .cfg_regs(cfgw));

    assign bus0.mem_sel_en  = sel_en[0];
    assign bus0.mem_wr_rd_s = wr_rd[0];
    assign bus0.mem_addr    = addr[0];
    assign bus0.mem_wr_data = wdata[0][7:0];
    assign bus1.mem_sel_en  = sel_en[1];
    assign bus1.mem_wr_rd_s = wr_rd[1];
    assign bus1.mem_addr    = addr[1];
    assign bus1.mem_wr_data = wdata[1][7:0];
    assign bus2.mem_sel_en  = sel_en[2];
    assign bus2.mem_wr_rd_s = wr_rd[2];
    assign bus2.mem_addr    = addr[2];
    assign bus2.mem_wr_data = wdata[2][7:0];
    assign busw.mem_sel_en  = sel_en[3];
    assign busw.mem_wr_rd_s = wr_rd[3];
    assign busw.mem_addr    = addr[3][3:0];
    assign busw.mem_wr_data = wdata[3];

    assign ack = {busw.mem_ack, bus2.mem_ack, bus1.mem_ack, bus0.mem_ack};
    assign err = {busw.mem_err, bus2.mem_err, bus1.mem_err, bus0.mem_err};
    assign rdata[0] = {8'h00, bus0.mem_rd_data};
    assign rdata[1] = {8'h00, bus1.mem_rd_data};
    assign rdata[2] = {8'h00, bus2.mem_rd_data};
    assign rdata[3] = busw.mem_rd_data;
    assign cfg[0] = cfg0;
    assign cfg[1] = cfg1;
    assign cfg[2] = cfg2;
    assign cfg[3] = {64'h0, cfgw};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction: drive, count cycles to ack, check response, release.
    task automatic txn(input int k, input logic wr, input logic [7:0] a, input logic [15:0] d,
                       input int lat, input logic [15:0] exp_rd, input logic exp_err,
                       input string tag);
        int n;
        sel_en[k] = 1'b1;
        wr_rd[k]  = wr;
        addr[k]   = a;
        wdata[k]  = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack[k] && n < 20);
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " err"}, 128'(err[k]), 128'(exp_err));
        check({tag, " rd_data"}, 128'(rdata[k]), 128'(exp_rd));
        cfg_snap = cfg[k];
        sel_en[k] = 1'b0;
        wr_rd[k]  = 1'b0;
        @(posedge clk); #1;
        check({tag, " ack low after"}, 128'(ack[k]), 128'(1'b0));
        check({tag, " rd_data low after"}, 128'(rdata[k]), 128'(16'h0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int n;
        rst    = 4'hF;
        sel_en = 4'h0;
        wr_rd  = 4'h0;
        for (int k = 0; k < 4; k++) begin
            addr[k]  = 8'h00;
            wdata[k] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 4'h0;

        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset ack[%0d]", k), 128'(ack[k]), 128'(1'b0));
            check($sformatf("reset err[%0d]", k), 128'(err[k]), 128'(1'b0));
            check($sformatf("reset rd_data[%0d]", k), 128'(rdata[k]), 128'(16'h0));
        end
        check("reset cfg l1", cfg[0], {120'h0, 8'hA5});
        check("reset cfg wide", cfg[3], {64'h0, 48'h0, 16'h00A5});

        // Latency 1: ID read, illegal accesses, top-of-range register
        txn(0, 1'b0, 8'd0, 16'h0000, 1, 16'h00A5, 1'b0, "l1 read id");
        txn(0, 1'b1, 8'd0, 16'h00FF, 1, 16'h0000, 1'b1, "l1 write id");
        check("l1 cfg after id write", cfg[0], {120'h0, 8'hA5});
        txn(0, 1'b1, 8'd16, 16'h005A, 1, 16'h0000, 1'b1, "l1 write addr16");
        check("l1 cfg after addr16 write", cfg[0], {120'h0, 8'hA5});
        txn(0, 1'b0, 8'd200, 16'h0000, 1, 16'h0000, 1'b1, "l1 read addr200");
        txn(0, 1'b1, 8'd15, 16'h0099, 1, 16'h0000, 1'b0, "l1 write addr15");
        check("l1 cfg addr15", cfg[0], {8'h99, 112'h0, 8'hA5});
        txn(0, 1'b0, 8'd15, 16'h0000, 1, 16'h0099, 1'b0, "l1 read addr15");

        // Latency 3: write/read-back and held request
        txn(1, 1'b1, 8'd5, 16'h003C, 3, 16'h0000, 1'b0, "l3 write addr5");
        check("l3 cfg in ack cycle", cfg_snap, {80'h0, 8'h3C, 32'h0, 8'hA5});
        txn(1, 1'b0, 8'd5, 16'h0000, 3, 16'h003C, 1'b0, "l3 read addr5");

        sel_en[1] = 1'b1;
        wr_rd[1]  = 1'b1;
        addr[1]   = 8'd2;
        wdata[1]  = 16'h0011;
        acks = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack[1]) acks++;
        end
        check("l3 held sel_en ack count", 128'(acks), 128'(1));
        sel_en[1] = 1'b0;
        @(posedge clk); #1;
        check("l3 cfg held write", cfg[1], {80'h0, 8'h3C, 16'h0, 8'h11, 8'h0, 8'hA5});
        txn(1, 1'b1, 8'd2, 16'h0022, 3, 16'h0000, 1'b0, "l3 rewrite addr2");
        check("l3 cfg rewrite", cfg[1], {80'h0, 8'h3C, 16'h0, 8'h22, 8'h0, 8'hA5});

        // Latency 4: reset in the middle of a write
        txn(2, 1'b1, 8'd7, 16'h005E, 4, 16'h0000, 1'b0, "l4 write addr7");
        check("l4 cfg addr7", cfg[2], {64'h0, 8'h5E, 48'h0, 8'hA5});
        sel_en[2] = 1'b1;
        wr_rd[2]  = 1'b1;
        addr[2]   = 8'd3;
        wdata[2]  = 16'h0077;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        acks = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack[2]) acks++;
        end
        rst[2] = 1'b0;
        check("l4 no ack across reset", 128'(acks), 128'(0));
        check("l4 cfg cleared by reset", cfg[2], {120'h0, 8'hA5});
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack[2] && n < 20);
        check("l4 post-reset latency", 128'(n), 128'(4));
        check("l4 post-reset err", 128'(err[2]), 128'(1'b0));
        check("l4 cfg post-reset write", cfg[2], {96'h0, 8'h77, 16'h0, 8'hA5});
        sel_en[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // 16-bit data, 4-bit address, depth 4, latency 2
        txn(3, 1'b1, 8'd3, 16'hBEEF, 2, 16'h0000, 1'b0, "wide write addr3");
        txn(3, 1'b0, 8'd3, 16'h0000, 2, 16'hBEEF, 1'b0, "wide read addr3");
        txn(3, 1'b0, 8'd4, 16'h0000, 2, 16'h0000, 1'b1, "wide read addr4");
        txn(3, 1'b1, 8'd4, 16'h1234, 2, 16'h0000, 1'b1, "wide write addr4");
        check("wide cfg", cfg[3], {64'h0, 16'hBEEF, 32'h0, 16'h00A5});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
